branch_seq_ctrl: RTL and testbench

- ID-stage branch sequencer for the 5-stage pipeline.
- Owns the branch compare unit: drives its BranchOp and operand forwarding selects, samples its Zero result, and issues the PC-select and IF/ID flush.
- Inserts the 1- or 2-cycle stalls needed when a branch operand is still in flight.
- Keeps wrapping counters of resolved and taken branches for performance readout.

---
 rtl/branch_seq_if.sv | 46 ++++
 rtl/branch_seq_ctrl.sv | 114 +++++++++++
 tb/tb_branch_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_seq_if.sv
// Signal bundle between the ID-stage pipeline/compare unit and branch_seq_ctrl.
// The pipeline side drives hazard and branch info; the controller answers with stalls, forwards and PC select.
interface branch_seq_if #(
    parameter int CNT_W = 16
);
    logic             id_branch;
    logic [2:0]       id_branch_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_kill;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic [4:0]       mem_rd;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic             cmp_zero;
    logic [2:0]       cmp_branch_op;
    logic [1:0]       fwd_rs_sel;
    logic [1:0]       fwd_rt_sel;
    logic             stall;
    logic             pc_src;
    logic             flush_if_id;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output id_branch, id_branch_op, id_rs, id_rt, id_kill,
               ex_reg_write, ex_mem_read, ex_rd,
               mem_reg_write, mem_mem_read, mem_rd,
               wb_reg_write, wb_rd, cmp_zero,
        input  cmp_branch_op, fwd_rs_sel, fwd_rt_sel, stall, pc_src,
               flush_if_id, br_count, taken_count
    );

    modport slave (
        input  id_branch, id_branch_op, id_rs, id_rt, id_kill,
               ex_reg_write, ex_mem_read, ex_rd,
               mem_reg_write, mem_mem_read, mem_rd,
               wb_reg_write, wb_rd, cmp_zero,
        output cmp_branch_op, fwd_rs_sel, fwd_rt_sel, stall, pc_src,
               flush_if_id, br_count, taken_count
    );
endinterface

// File: rtl/branch_seq_ctrl.sv
// ID-stage branch sequencer: hazard stalls, compare-unit operand forwarding,
// PC select / IF-ID flush and wrapping resolved/taken branch counters.
module branch_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    branch_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESOLVE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [1:0]       stall_cnt, stall_cnt_nxt;
    logic [CNT_W-1:0] br_cnt, taken_cnt;
    logic             op_ok, ex_dep, mem_dep_rs, mem_dep_rt, wb_dep_rs, wb_dep_rt;
    logic             resolve, stall_int;

    function automatic logic depends(input logic we, input logic [4:0] rd, input logic [4:0] src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) return 2'b01;
        if (wb_hit)  return 2'b10;
        return 2'b00;
    endfunction

    assign op_ok      = (bus.id_branch_op == 3'b000) || (bus.id_branch_op == 3'b001);
    assign ex_dep     = depends(bus.ex_reg_write, bus.ex_rd, bus.id_rs) ||
                        depends(bus.ex_reg_write, bus.ex_rd, bus.id_rt);
    assign mem_dep_rs = depends(bus.mem_reg_write, bus.mem_rd, bus.id_rs);
    assign mem_dep_rt = depends(bus.mem_reg_write, bus.mem_rd, bus.id_rt);
    assign wb_dep_rs  = depends(bus.wb_reg_write, bus.wb_rd, bus.id_rs);
    assign wb_dep_rt  = depends(bus.wb_reg_write, bus.wb_rd, bus.id_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stall_cnt <= 2'd0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            if (resolve) begin
                br_cnt <= br_cnt + CNT_ONE;
                if (bus.cmp_zero) taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end

    // Outputs are held quiet while reset is asserted, even with a hazard on the inputs.
    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        stall_int     = 1'b0;
        resolve       = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (bus.id_branch && op_ok && !bus.id_kill) begin
                        if (ex_dep && bus.ex_mem_read) begin
                            stall_cnt_nxt = 2'd1;
                            state_nxt     = WAIT;
                            stall_int     = 1'b1;
                        end else if (ex_dep) begin
                            state_nxt = RESOLVE;
                            stall_int = 1'b1;
                        end else if ((mem_dep_rs || mem_dep_rt) && bus.mem_mem_read) begin
                            state_nxt = RESOLVE;
                            stall_int = 1'b1;
                        end else begin
                            resolve = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.id_kill || !bus.id_branch) begin
                        state_nxt     = IDLE;
                        stall_cnt_nxt = 2'd0;
                    end else begin
                        stall_int = 1'b1;
                        // stall_cnt holds the WAIT cycles still owed; the last one hands over to RESOLVE.
                        if (stall_cnt <= 2'd1) begin
                            stall_cnt_nxt = 2'd0;
                            state_nxt     = RESOLVE;
                        end else begin
                            stall_cnt_nxt = stall_cnt - 2'd1;
                        end
                    end
                end
                RESOLVE: begin
                    state_nxt = IDLE;
                    resolve   = bus.id_branch && !bus.id_kill;
                end
                default: begin
                    state_nxt     = IDLE;
                    stall_cnt_nxt = 2'd0;
                end
            endcase
        end
    end

    assign bus.stall         = stall_int;
    assign bus.cmp_branch_op = resolve ? bus.id_branch_op : 3'b000;
    assign bus.fwd_rs_sel    = resolve ? fwd_sel(mem_dep_rs, wb_dep_rs) : 2'b00;
    assign bus.fwd_rt_sel    = resolve ? fwd_sel(mem_dep_rt, wb_dep_rt) : 2'b00;
    assign bus.pc_src        = resolve && bus.cmp_zero;
    assign bus.flush_if_id   = resolve && bus.cmp_zero;
    assign bus.br_count      = br_cnt;
    assign bus.taken_count   = taken_cnt;
endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a stall-count reference model.
module tb_branch_seq_ctrl;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_seq_if #(.CNT_W(CNT_W)) bus();
    branch_seq_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        bit br; bit [2:0] op; bit [4:0] rs; bit [4:0] rt; bit kill;
        bit exw; bit exm; bit [4:0] exrd;
        bit mw; bit mm; bit [4:0] mrd;
        bit ww; bit [4:0] wrd; bit zero;
    } in_t;
    typedef struct { bit stall; bit pc; bit [2:0] cop; bit [1:0] frs; bit [1:0] frt; } out_t;
    typedef struct { string name; in_t i; out_t o; } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit m_busy = 0;
    int m_pend = 0;
    int m_br = 0;
    int m_tk = 0;
    int br0, tk0;
    vec_t tbl[12];
    in_t rv, idle_in, kill_in, nohaz, ld, ld_mem, ld_res;
    out_t re, zero_out;

    function automatic in_t mk_in(bit br, bit [2:0] op, bit [4:0] rs, bit [4:0] rt, bit kill,
                                  bit exw, bit exm, bit [4:0] exrd, bit mw, bit mm, bit [4:0] mrd,
                                  bit ww, bit [4:0] wrd, bit zero);
        in_t v;
        v.br = br; v.op = op; v.rs = rs; v.rt = rt; v.kill = kill;
        v.exw = exw; v.exm = exm; v.exrd = exrd;
        v.mw = mw; v.mm = mm; v.mrd = mrd;
        v.ww = ww; v.wrd = wrd; v.zero = zero;
        return v;
    endfunction

    function automatic out_t mk_out(bit stall, bit pc, bit [2:0] cop, bit [1:0] frs, bit [1:0] frt);
        out_t o;
        o.stall = stall; o.pc = pc; o.cop = cop; o.frs = frs; o.frt = frt;
        return o;
    endfunction

    function automatic bit hit(bit we, bit [4:0] rd, bit [4:0] r);
        return we && rd != 5'd0 && rd == r;
    endfunction

    function automatic bit [1:0] src_sel(in_t v, bit [4:0] r);
        if (hit(v.mw, v.mrd, r)) return 2'b01;
        if (hit(v.ww, v.wrd, r)) return 2'b10;
        return 2'b00;
    endfunction

    // Reference: a branch owes n stall cycles (2 load-use in EX, 1 ALU in EX or load in MEM), then resolves.
    task automatic model_step(input in_t v, output out_t e);
        int n;
        bit do_res;
        e = mk_out(1'b0, 1'b0, 3'd0, 2'd0, 2'd0);
        do_res = 1'b0;
        if (v.kill) begin
            m_busy = 1'b0;
            m_pend = 0;
        end else if (!m_busy) begin
            if (v.br && v.op <= 3'd1) begin
                n = 0;
                if (hit(v.exw, v.exrd, v.rs) || hit(v.exw, v.exrd, v.rt)) n = v.exm ? 2 : 1;
                else if (v.mm && (hit(v.mw, v.mrd, v.rs) || hit(v.mw, v.mrd, v.rt))) n = 1;
                if (n == 0) do_res = 1'b1;
                else begin
                    e.stall = 1'b1;
                    m_busy = 1'b1;
                    m_pend = n - 1;
                end
            end
        end else if (!v.br) begin
            m_busy = 1'b0;
        end else if (m_pend > 0) begin
            e.stall = 1'b1;
            m_pend = m_pend - 1;
        end else begin
            do_res = 1'b1;
            m_busy = 1'b0;
        end
        if (do_res) begin
            e.cop = v.op;
            e.frs = src_sel(v, v.rs);
            e.frt = src_sel(v, v.rt);
            e.pc = v.zero;
            m_br = (m_br + 1) % 65536;
            if (v.zero) m_tk = (m_tk + 1) % 65536;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t e);
        chk({tag, " stall"}, bus.stall, e.stall);
        chk({tag, " pc_src"}, bus.pc_src, e.pc);
        chk({tag, " flush"}, bus.flush_if_id, e.pc);
        chk({tag, " cmp_op"}, bus.cmp_branch_op, e.cop);
        chk({tag, " fwd_rs"}, bus.fwd_rs_sel, e.frs);
        chk({tag, " fwd_rt"}, bus.fwd_rt_sel, e.frt);
    endtask

    task automatic drive(input in_t v);
        bus.id_branch = v.br;       bus.id_branch_op = v.op;
        bus.id_rs = v.rs;           bus.id_rt = v.rt;           bus.id_kill = v.kill;
        bus.ex_reg_write = v.exw;   bus.ex_mem_read = v.exm;    bus.ex_rd = v.exrd;
        bus.mem_reg_write = v.mw;   bus.mem_mem_read = v.mm;    bus.mem_rd = v.mrd;
        bus.wb_reg_write = v.ww;    bus.wb_rd = v.wrd;          bus.cmp_zero = v.zero;
    endtask

    // Inputs change after the falling edge; outputs and counters are sampled 2 ns later.
    task automatic cycle(input string tag, input in_t v, output out_t e);
        @(negedge clk);
        drive(v);
        #2;
        chk({tag, " br_count"}, bus.br_count, m_br);
        chk({tag, " taken_count"}, bus.taken_count, m_tk);
        model_step(v, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(idle_in);
        rst_n = 1'b0;
        #2;
        m_busy = 1'b0; m_pend = 0; m_br = 0; m_tk = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_in  = mk_in(1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        kill_in  = mk_in(1'b0, 3'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        nohaz    = mk_in(1'b1, 3'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        ld       = mk_in(1'b1, 3'd0, 5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        ld_mem   = mk_in(1'b1, 3'd0, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1);
        ld_res   = mk_in(1'b1, 3'd0, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1);
        zero_out = mk_out(1'b0, 1'b0, 3'd0, 2'd0, 2'd0);

        tbl[0]  = '{"nohaz",    mk_in(1'b1, 3'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1), mk_out(1'b0, 1'b1, 3'd0, 2'd0, 2'd0)};
        tbl[1]  = '{"ex_alu",   mk_in(1'b1, 3'd1, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0)};
        tbl[2]  = '{"ex_load",  mk_in(1'b1, 3'd0, 5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1), mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0)};
        tbl[3]  = '{"r0",       mk_in(1'b1, 3'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1), mk_out(1'b0, 1'b1, 3'd0, 2'd0, 2'd0)};
        tbl[4]  = '{"wb_rt",    mk_in(1'b1, 3'd0, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0), mk_out(1'b0, 1'b0, 3'd0, 2'd0, 2'd2)};
        tbl[5]  = '{"mem_rs",   mk_in(1'b1, 3'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b1), mk_out(1'b0, 1'b1, 3'd1, 2'd1, 2'd0)};
        tbl[6]  = '{"mem_load", mk_in(1'b1, 3'd0, 5'd4, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1), mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0)};
        tbl[7]  = '{"bad_op",   mk_in(1'b1, 3'd3, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1), mk_out(1'b0, 1'b0, 3'd0, 2'd0, 2'd0)};
        tbl[8]  = '{"no_br",    mk_in(1'b0, 3'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1), mk_out(1'b0, 1'b0, 3'd0, 2'd0, 2'd0)};
        tbl[9]  = '{"kill",     mk_in(1'b1, 3'd0, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1), mk_out(1'b0, 1'b0, 3'd0, 2'd0, 2'd0)};
        tbl[10] = '{"mem_pri",  mk_in(1'b1, 3'd1, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 5'd6, 1'b0), mk_out(1'b0, 1'b0, 3'd1, 2'd1, 2'd1)};
        tbl[11] = '{"no_dep",   mk_in(1'b1, 3'd0, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 5'd11, 1'b0), mk_out(1'b0, 1'b0, 3'd0, 2'd0, 2'd0)};

        // Reset state
        drive(nohaz);
        #3;
        chk_out("reset", zero_out);
        chk("reset br_count", bus.br_count, 0);
        chk("reset taken_count", bus.taken_count, 0);
        @(negedge clk);
        drive(idle_in);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            cycle(tbl[k].name, tbl[k].i, re);
            chk_out(tbl[k].name, tbl[k].o);
            cycle("tbl_kill", kill_in, re);
            chk_out("tbl_kill", zero_out);
        end
        cycle("tbl_end", idle_in, re);

        // ALU result in EX: one stall, then forwarded from EX/MEM
        br0 = m_br; tk0 = m_tk;
        cycle("aluA0", mk_in(1'b1, 3'd1, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), re);
        chk_out("aluA0", mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0));
        cycle("aluA1", mk_in(1'b1, 3'd1, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0), re);
        chk_out("aluA1", mk_out(1'b0, 1'b0, 3'd1, 2'd1, 2'd0));
        cycle("aluA2", idle_in, re);
        chk_out("aluA2", zero_out);
        chk("aluA br+1", bus.br_count, (br0 + 1) % 65536);
        chk("aluA taken same", bus.taken_count, tk0);

        // Load in EX: two stalls, taken on resolve, pc_src for one cycle only
        br0 = m_br; tk0 = m_tk;
        cycle("ldB0", ld, re);      chk_out("ldB0", mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0));
        cycle("ldB1", ld_mem, re);  chk_out("ldB1", mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0));
        cycle("ldB2", ld_res, re);  chk_out("ldB2", mk_out(1'b0, 1'b1, 3'd0, 2'd0, 2'd1));
        cycle("ldB3", idle_in, re); chk_out("ldB3", zero_out);
        chk("ldB br+1", bus.br_count, (br0 + 1) % 65536);
        chk("ldB taken+1", bus.taken_count, (tk0 + 1) % 65536);

        // Kill on the second cycle of a load-use wait
        br0 = m_br; tk0 = m_tk;
        cycle("killC0", ld, re);    chk_out("killC0", mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0));
        rv = ld; rv.kill = 1'b1;
        cycle("killC1", rv, re);    chk_out("killC1", zero_out);
        cycle("killC2", idle_in, re); chk_out("killC2", zero_out);
        cycle("killC3", idle_in, re); chk_out("killC3", zero_out);
        chk("killC br same", bus.br_count, br0);
        chk("killC taken same", bus.taken_count, tk0);

        // Branch withdrawn while waiting
        cycle("dropD0", ld, re);
        cycle("dropD1", idle_in, re);
        chk("dropD1 pc_src", bus.pc_src, 0);
        chk("dropD1 cmp_op", bus.cmp_branch_op, 0);
        cycle("dropD2", idle_in, re);
        chk("dropD br same", bus.br_count, br0);

        // Reset pulse in the middle of a WAIT cycle
        cycle("rstE0", ld, re);     chk_out("rstE0", re);
        cycle("rstE1", ld, re);     chk_out("rstE1", mk_out(1'b1, 1'b0, 3'd0, 2'd0, 2'd0));
        #1 rst_n = 1'b0;
        #1;
        chk_out("rstE async", zero_out);
        chk("rstE br_count", bus.br_count, 0);
        chk("rstE taken_count", bus.taken_count, 0);
        m_busy = 1'b0; m_pend = 0; m_br = 0; m_tk = 0;
        @(negedge clk);
        drive(idle_in);
        rst_n = 1'b1;
        cycle("rstE2", idle_in, re); chk_out("rstE2", zero_out);
        cycle("rstE3", idle_in, re); chk_out("rstE3", zero_out);

        // Counter wrap: 0xFFFF taken branches, then one more
        do_reset();
        for (int k = 0; k < 65535; k++) cycle("wrap", nohaz, re);
        cycle("wrap_last", nohaz, re);
        chk("wrap pre br", bus.br_count, 16'hFFFF);
        chk("wrap pre taken", bus.taken_count, 16'hFFFF);
        chk_out("wrap_last", mk_out(1'b0, 1'b1, 3'd0, 2'd0, 2'd0));
        rv = nohaz; rv.op = 3'b011;
        cycle("bad_op", rv, re);
        chk("wrap br", bus.br_count, 0);
        chk("wrap taken", bus.taken_count, 0);
        chk_out("bad_op", zero_out);
        cycle("bad_op_after", idle_in, re);
        chk("bad_op br", bus.br_count, 0);

        // Randomized run against the reference model
        for (int k = 0; k < 3000; k++) begin
            rv.br   = $urandom_range(0, 9) < 8;
            rv.op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            rv.rs   = 5'($urandom_range(0, 7));
            rv.rt   = 5'($urandom_range(0, 7));
            rv.kill = $urandom_range(0, 19) == 0;
            rv.exw  = $urandom_range(0, 1) == 1;
            rv.exm  = $urandom_range(0, 2) == 0;
            rv.exrd = 5'($urandom_range(0, 7));
            rv.mw   = $urandom_range(0, 1) == 1;
            rv.mm   = $urandom_range(0, 2) == 0;
            rv.mrd  = 5'($urandom_range(0, 7));
            rv.ww   = $urandom_range(0, 1) == 1;
            rv.wrd  = 5'($urandom_range(0, 7));
            rv.zero = $urandom_range(0, 1) == 1;
            cycle("rnd", rv, re);
            chk_out("rnd", re);
        end
        cycle("rnd_end", idle_in, re);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
